// File: rtl/speck32_pkg.sv
// Shared SPECK32/64 types and constants for the key schedule and round datapath.
// No logic; pure declarations plus the fixed-amount rotations.
// Rotations are wiring only and carry no latency.
package speck32_pkg;

    localparam int WORD           = 16;
    localparam int ALPHA          = 7;
    localparam int BETA           = 2;
    localparam int SPECK32_ROUNDS = 22;

    typedef logic [WORD-1:0] word_t;

    // Master key layout as presented on key_in: l2 in the top word, k0 in the bottom.
    typedef struct packed {
        word_t l2;
        word_t l1;
        word_t l0;
        word_t k0;
    } key64_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic word_t ror_alpha(input word_t x);
        return {x[ALPHA-1:0], x[WORD-1:ALPHA]};
    endfunction

    function automatic word_t rol_beta(input word_t x);
        return {x[WORD-BETA-1:0], x[WORD-1:WORD-BETA]};
    endfunction

endpackage

// File: rtl/speck32_ks_step.sv
// One SPECK32/64 key-expansion ARX step: lnew and the next round key.
// Purely combinational, zero latency.
// No flow control; the caller decides when to commit the result.
module speck32_ks_step
    import speck32_pkg::*;
#(
    parameter int IDX_W = 5
) (
    input  word_t             la,
    input  word_t             k,
    input  logic [IDX_W-1:0]  idx,
    output word_t             lnew,
    output word_t             knext
);

    word_t sum;

    // Carry out of the 16-bit add is intentionally dropped.
    assign sum   = ror_alpha(la) + k;
    assign lnew  = sum ^ word_t'(idx);
    assign knext = rol_beta(k) ^ lnew;

endmodule

// File: rtl/speck32_key_sched.sv
// Iterative SPECK32/64 key expansion streaming rk[0..ROUNDS-1] over valid/ready.
// key_load at t gives rk[0] at t+1; one new key per cycle while rk_ready is held.
// A stall (rk_valid && !rk_ready) freezes all state and outputs; key_load always wins.
module speck32_key_sched
    import speck32_pkg::*;
#(
    parameter int ROUNDS = 22,
    parameter int IDX_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_load,
    input  logic [63:0]       key_in,
    output logic              rk_valid,
    input  logic              rk_ready,
    output logic [WORD-1:0]   rk_data,
    output logic [IDX_W-1:0]  rk_idx,
    output logic              rk_last,
    output logic              busy
);

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(ROUNDS - 1);
    localparam logic [IDX_W-1:0] PENULT_IDX = IDX_W'(ROUNDS - 2);

    state_t           state;
    word_t            k;
    word_t            la;
    word_t            lb;
    word_t            lc;
    logic [IDX_W-1:0] idx;

    key64_t key_s;
    word_t  lnew;
    word_t  knext;
    logic   fire;

    assign key_s = key_in;
    assign fire  = rk_valid && rk_ready;

    speck32_ks_step #(
        .IDX_W (IDX_W)
    ) u_step (
        .la    (la),
        .k     (k),
        .idx   (idx),
        .lnew  (lnew),
        .knext (knext)
    );

    // Round key and index are the state registers themselves.
    assign rk_data = k;
    assign rk_idx  = idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            k        <= '0;
            la       <= '0;
            lb       <= '0;
            lc       <= '0;
            idx      <= '0;
            rk_valid <= 1'b0;
            rk_last  <= 1'b0;
            busy     <= 1'b0;
        end else if (key_load) begin
            // Restart from any state, even over a same-cycle fire of the last key.
            state    <= RUN;
            k        <= key_s.k0;
            la       <= key_s.l0;
            lb       <= key_s.l1;
            lc       <= key_s.l2;
            idx      <= '0;
            rk_valid <= 1'b1;
            rk_last  <= 1'b0;
            busy     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    rk_valid <= 1'b0;
                    rk_last  <= 1'b0;
                    busy     <= 1'b0;
                end
                RUN: begin
                    if (fire) begin
                        if (idx == LAST_IDX) begin
                            state    <= IDLE;
                            rk_valid <= 1'b0;
                            rk_last  <= 1'b0;
                            busy     <= 1'b0;
                        end else begin
                            k       <= knext;
                            la      <= lb;
                            lb      <= lc;
                            lc      <= lnew;
                            idx     <= idx + IDX_W'(1);
                            rk_last <= (idx == PENULT_IDX);
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    rk_valid <= 1'b0;
                    rk_last  <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_speck32_key_sched.sv
// Directed bench for speck32_key_sched: golden-model scoreboard plus end-to-end cipher check.
module tb_speck32_key_sched;

    localparam int ROUNDS = 22;
    localparam int IDX_W  = 5;

    localparam logic [63:0] KEY_STD = 64'h1918_1110_0908_0100;
    localparam logic [63:0] KEY_A   = 64'h0123_4567_89ab_cdef;

    logic              clk = 1'b0;
    logic              rst;
    logic              key_load;
    logic [63:0]       key_in;
    logic              rk_valid;
    logic              rk_ready;
    logic [15:0]       rk_data;
    logic [IDX_W-1:0]  rk_idx;
    logic              rk_last;
    logic              busy;

    int n_vec = 0;
    int n_err = 0;
    int stalls = 0;

    logic [21:0] sb[$];
    logic [15:0] got[0:ROUNDS-1];
    logic        hold_vld = 1'b0;
    logic [15:0] hold_data;
    logic [4:0]  hold_idx;

    speck32_key_sched #(
        .ROUNDS (ROUNDS),
        .IDX_W  (IDX_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_load (key_load),
        .key_in   (key_in),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_data  (rk_data),
        .rk_idx   (rk_idx),
        .rk_last  (rk_last),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] ror7(input logic [15:0] x);
        return {x[6:0], x[15:7]};
    endfunction

    function automatic logic [15:0] rol2(input logic [15:0] x);
        return {x[13:0], x[15:14]};
    endfunction

    function automatic void push_key(input logic [63:0] key);
        logic [15:0] k;
        logic [15:0] l[0:ROUNDS+2];
        k    = key[15:0];
        l[0] = key[31:16];
        l[1] = key[47:32];
        l[2] = key[63:48];
        for (int i = 0; i < ROUNDS; i++) begin
            sb.push_back({(i == ROUNDS - 1), 5'(i), k});
            if (i < ROUNDS - 1) begin
                l[i+3] = (ror7(l[i]) + k) ^ 16'(i);
                k      = rol2(k) ^ l[i+3];
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: observe at negedge, score fires, track stalls, model load/reset.
    task automatic cycle();
        logic [21:0] e;
        @(negedge clk);
        if (hold_vld) begin
            chk("stall_data", 64'(rk_data), 64'(hold_data));
            chk("stall_idx", 64'(rk_idx), 64'(hold_idx));
        end
        hold_vld = 1'b0;
        if (rk_valid && rk_ready) begin
            chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("rk_last_idx_data", 64'({rk_last, rk_idx, rk_data}), 64'(e));
                if (int'(rk_idx) < ROUNDS) got[int'(rk_idx)] = rk_data;
            end
        end
        if (rk_valid && !rk_ready && !key_load && !rst) begin
            hold_vld  = 1'b1;
            hold_data = rk_data;
            hold_idx  = rk_idx;
            stalls++;
        end
        if (rst) sb.delete();
        else if (key_load) begin
            sb.delete();
            push_key(key_in);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [63:0] key, input logic rdy);
        key_in   = key;
        key_load = 1'b1;
        rk_ready = rdy;
        cycle();
        key_load = 1'b0;
        key_in   = {$urandom, $urandom};
    endtask

    task automatic drain(input int budget, input logic rnd);
        for (int c = 0; c < budget && sb.size() != 0; c++) begin
            rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            cycle();
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic run_to_idx(input int target);
        rk_ready = 1'b1;
        for (int c = 0; c < 60 && !(rk_valid && int'(rk_idx) == target); c++) cycle();
        chk("reach_idx", 64'(rk_idx), 64'(target));
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_valid"}, 64'(rk_valid), 64'd0);
        chk({tag, "_data"}, 64'(rk_data), 64'd0);
        chk({tag, "_idx"}, 64'(rk_idx), 64'd0);
        chk({tag, "_last"}, 64'(rk_last), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [15:0] x;
        logic [15:0] y;
        rst      = 1'b1;
        key_load = 1'b0;
        key_in   = '0;
        rk_ready = 1'b0;
        cycle();
        cycle();
        check_idle("reset");
        rst = 1'b0;
        cycle();

        // Standard vector with ready held high.
        load(KEY_STD, 1'b1);
        chk("std_first_valid", 64'(rk_valid), 64'd1);
        chk("std_first_busy", 64'(busy), 64'd1);
        chk("std_rk0", 64'(rk_data), 64'h0100);
        chk("std_idx0", 64'(rk_idx), 64'd0);
        cycle();
        chk("std_rk1", 64'(rk_data), 64'h1512);
        chk("std_idx1", 64'(rk_idx), 64'd1);
        drain(100, 1'b0);
        chk("std_end_valid", 64'(rk_valid), 64'd0);
        chk("std_end_busy", 64'(busy), 64'd0);

        // Round datapath fed from the emitted key stream.
        x = 16'h6574;
        y = 16'h694c;
        for (int i = 0; i < ROUNDS; i++) begin
            x = (ror7(x) + y) ^ got[i];
            y = rol2(y) ^ x;
        end
        chk("ciphertext", 64'({x, y}), 64'ha868_42f2);

        // Backpressure with pseudo-random ready.
        load(KEY_STD, 1'b0);
        drain(600, 1'b1);
        chk("stalls_seen", 64'(stalls != 0), 64'd1);
        chk("bp_end_valid", 64'(rk_valid), 64'd0);

        // Restart mid-run with an all-zero key.
        load(KEY_A, 1'b1);
        run_to_idx(6);
        load(64'h0, 1'b1);
        chk("restart_valid", 64'(rk_valid), 64'd1);
        chk("restart_idx", 64'(rk_idx), 64'd0);
        chk("restart_data", 64'(rk_data), 64'h0000);
        drain(100, 1'b0);

        // Load coinciding with the fire of the last key.
        load(KEY_STD, 1'b1);
        rk_ready = 1'b1;
        for (int c = 0; c < 60 && !rk_last; c++) cycle();
        chk("reach_last", 64'(rk_last), 64'd1);
        chk("reach_last_idx", 64'(rk_idx), 64'(ROUNDS - 1));
        load(KEY_A, 1'b1);
        chk("lastload_valid", 64'(rk_valid), 64'd1);
        chk("lastload_idx", 64'(rk_idx), 64'd0);
        chk("lastload_data", 64'(rk_data), 64'hcdef);
        drain(100, 1'b0);

        // Reset in the middle of an expansion.
        load(KEY_STD, 1'b1);
        run_to_idx(10);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_idle("midrst");
        cycle();
        load(KEY_STD, 1'b1);
        chk("after_rst_rk0", 64'(rk_data), 64'h0100);
        drain(100, 1'b0);
        chk("after_rst_end_valid", 64'(rk_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
